// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the RV32I multicycle control slice.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6,
    ST_FAULT  = 3'd7
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_HALT   = 7'b0000000;

  localparam logic [1:0] WB_DM  = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic OP1_PC  = 1'b0;
  localparam logic OP1_RS1 = 1'b1;
  localparam logic OP2_RS2 = 1'b0;
  localparam logic OP2_IMM = 1'b1;

  typedef struct packed {
    logic       is_branch;
    logic       is_mem;
    logic       is_store;
    logic       is_jump;
    logic       rf_wr;
    logic       op1_sel;
    logic       op2_sel;
    logic [1:0] wb_sel;
    logic [2:0] alu_func3;
    logic       alu_subsra;
    logic [2:0] br_op;
    logic [2:0] func3;
  } ctl_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode classifier producing per-instruction mux selects.
module instr_decoder
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic       bit30,
  output logic       legal,
  output logic       halt,
  output ctl_t       ctl
);

  always_comb begin
    legal         = 1'b1;
    halt          = 1'b0;
    ctl           = '0;
    ctl.func3     = func3;
    ctl.op1_sel   = OP1_RS1;
    ctl.op2_sel   = OP2_IMM;
    ctl.wb_sel    = WB_ALU;
    ctl.rf_wr     = 1'b1;
    case (opcode)
      OP_R: begin
        ctl.op2_sel    = OP2_RS2;
        ctl.alu_func3  = func3;
        ctl.alu_subsra = bit30;
      end
      OP_IMM: begin
        ctl.alu_func3  = func3;
        ctl.alu_subsra = (func3 == 3'b101) & bit30;
      end
      OP_LOAD: begin
        ctl.is_mem = 1'b1;
        ctl.wb_sel = WB_DM;
      end
      OP_STORE: begin
        ctl.is_mem   = 1'b1;
        ctl.is_store = 1'b1;
        ctl.rf_wr    = 1'b0;
      end
      OP_BRANCH: begin
        ctl.is_branch = 1'b1;
        ctl.op1_sel   = OP1_PC;
        ctl.br_op     = func3;
        ctl.rf_wr     = 1'b0;
      end
      OP_JAL: begin
        ctl.is_jump = 1'b1;
        ctl.op1_sel = OP1_PC;
        ctl.wb_sel  = WB_PC4;
      end
      OP_JALR: begin
        ctl.is_jump = 1'b1;
        ctl.wb_sel  = WB_PC4;
      end
      OP_HALT: halt  = 1'b1;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Registered Moore sequencer for the multicycle RV32I datapath, with
// data-memory handshake timeout and cycle / retired-instruction counters.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [31:0]      instr,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic             rf_we,
  output logic [2:0]       alu_func3,
  output logic             alu_subsra,
  output logic             op1_sel,
  output logic             op2_sel,
  output logic [1:0]       wb_sel,
  output logic [2:0]       br_op,
  output logic             mem_req,
  output logic             dm_we,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  localparam int unsigned WAIT_W = $clog2(WAIT_LIMIT + 1);

  state_t            state_q, state_d;
  ctl_t              ctl_live, ctl_q, ctl;
  logic              dec_legal, dec_halt;
  logic [WAIT_W-1:0] wait_q;
  logic              unused_instr;

  assign unused_instr = ^{instr[31], instr[29:25]};

  instr_decoder u_dec (
    .opcode (instr[6:0]),
    .func3  (instr[14:12]),
    .bit30  (instr[30]),
    .legal  (dec_legal),
    .halt   (dec_halt),
    .ctl    (ctl_live)
  );

  // Outputs are loaded on the edge entering their state, so the edge leaving
  // DECODE must see the live decode rather than the not-yet-captured copy.
  assign ctl = (state_q == ST_DECODE) ? ctl_live : ctl_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (run) state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        if (dec_halt)        state_d = ST_HALT;
        else if (!dec_legal) state_d = ST_FAULT;
        else                 state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (ctl.is_branch)   state_d = run ? ST_FETCH : ST_IDLE;
        else if (ctl.is_mem) state_d = ST_MEM;
        else                 state_d = ST_WB;
      end
      ST_MEM: begin
        if (mem_ready)                              state_d = ST_WB;
        else if (wait_q == WAIT_W'(WAIT_LIMIT - 1)) state_d = ST_FAULT;
      end
      ST_WB:   state_d = run ? ST_FETCH : ST_IDLE;
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      ctl_q       <= '0;
      rs1         <= '0;
      rs2         <= '0;
      rd          <= '0;
      wait_q      <= '0;
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DECODE) begin
        ctl_q <= ctl_live;
        rs1   <= instr[19:15];
        rs2   <= instr[24:20];
        rd    <= instr[11:7];
      end
      wait_q <= (state_q == ST_MEM && !mem_ready) ? wait_q + WAIT_W'(1) : '0;
      if (!(state_q inside {ST_IDLE, ST_HALT, ST_FAULT}))
        cycle_cnt <= cycle_cnt + CNT_W'(1);
      if ((state_q == ST_EXEC && ctl_q.is_branch) || state_q == ST_WB)
        instret_cnt <= instret_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir_we      <= 1'b0;
      pc_we      <= 1'b0;
      pc_sel     <= 1'b0;
      rf_we      <= 1'b0;
      alu_func3  <= '0;
      alu_subsra <= 1'b0;
      op1_sel    <= 1'b0;
      op2_sel    <= 1'b0;
      wb_sel     <= '0;
      br_op      <= '0;
      mem_req    <= 1'b0;
      dm_we      <= 1'b0;
      halted     <= 1'b0;
      fault      <= 1'b0;
    end else begin
      ir_we      <= (state_d == ST_FETCH);
      pc_we      <= (state_d == ST_EXEC && ctl.is_branch) || (state_d == ST_WB);
      pc_sel     <= (state_d == ST_EXEC) ? (ctl.is_branch & branch_taken)
                                         : ((state_d == ST_WB) & ctl.is_jump);
      rf_we      <= (state_d == ST_WB) && ctl.rf_wr && (rd != 5'd0);
      alu_func3  <= (state_d == ST_EXEC) ? ctl.alu_func3 :
                    (state_d == ST_MEM)  ? ctl.func3 : 3'b000;
      alu_subsra <= (state_d == ST_EXEC) & ctl.alu_subsra;
      op1_sel    <= (state_d == ST_EXEC) & ctl.op1_sel;
      op2_sel    <= (state_d == ST_EXEC) & ctl.op2_sel;
      wb_sel     <= (state_d == ST_WB) ? ctl.wb_sel : WB_DM;
      br_op      <= (state_d == ST_EXEC) ? ctl.br_op : 3'b000;
      mem_req    <= (state_d == ST_MEM);
      dm_we      <= (state_d == ST_MEM) & ctl.is_store;
      halted     <= (state_d == ST_HALT);
      fault      <= (state_d == ST_FAULT);
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: randomized RV32I opcode stream
// against an instruction-level reference model, plus directed corner cases.
module tb_multicycle_ctrl;

  localparam int unsigned CNT_W      = 32;
  localparam int unsigned WAIT_LIMIT = 15;

  logic             clk = 1'b0, reset = 1'b0, run = 1'b0;
  logic             branch_taken = 1'b0, mem_ready = 1'b0;
  logic [31:0]      instr = '0;
  logic             ir_we, pc_we, pc_sel, rf_we, alu_subsra, op1_sel, op2_sel;
  logic             mem_req, dm_we, halted, fault;
  logic [4:0]       rs1, rs2, rd;
  logic [2:0]       alu_func3, br_op;
  logic [1:0]       wb_sel;
  logic [CNT_W-1:0] cycle_cnt, instret_cnt;

  multicycle_ctrl #(.CNT_W(CNT_W), .WAIT_LIMIT(WAIT_LIMIT)) dut (
    .clk(clk), .reset(reset), .run(run), .instr(instr),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .rs1(rs1), .rs2(rs2), .rd(rd), .rf_we(rf_we),
    .alu_func3(alu_func3), .alu_subsra(alu_subsra),
    .op1_sel(op1_sel), .op2_sel(op2_sel), .wb_sel(wb_sel), .br_op(br_op),
    .mem_req(mem_req), .dm_we(dm_we), .halted(halted), .fault(fault),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       op1, op2, subsra, pc_we, halted, fault;
    logic [2:0] func3, br_op;
    logic [4:0] rs1, rs2;
  } exec_exp_t;

  typedef struct {
    logic        pc_sel, rf_we;
    logic [4:0]  rd;
    logic [1:0]  wb_sel;
    int unsigned cyc, ret, mem_cyc, st_cyc;
  } ret_exp_t;

  exec_exp_t   exec_q[$];
  ret_exp_t    ret_q[$];
  exec_exp_t   e_m;
  ret_exp_t    r_m;
  int          tests = 0, fails = 0;
  int unsigned model_cycles = 0, model_retired = 0;
  int          cur_w = 0, mcnt = 0, mon_mem = 0, mon_st = 0;
  logic        prev_ir = 1'b0, exec_due = 1'b0;
  bit          ok;
  int          seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Data memory model: ready after cur_w wait cycles; random noise outside MEM.
  always @(negedge clk) begin
    if (mem_req) begin
      mem_ready = (mcnt == cur_w);
      mcnt++;
    end else begin
      mcnt      = 0;
      mem_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: EXEC is two cycles after the FETCH pulse; retirement is the pc_we pulse.
  always @(negedge clk) begin
    if (!reset) begin
      prev_ir = 1'b0; exec_due = 1'b0; mon_mem = 0; mon_st = 0;
    end else begin
      if (mem_req) mon_mem++;
      if (dm_we)   mon_st++;
      if (exec_due) begin
        if (exec_q.size() == 0) bound_fail("exec_unexpected");
        else begin
          e_m = exec_q.pop_front();
          check("exec_op1_sel", op1_sel, e_m.op1);
          check("exec_op2_sel", op2_sel, e_m.op2);
          check("exec_subsra", alu_subsra, e_m.subsra);
          check("exec_func3", alu_func3, e_m.func3);
          check("exec_br_op", br_op, e_m.br_op);
          check("exec_rs1", rs1, e_m.rs1);
          check("exec_rs2", rs2, e_m.rs2);
          check("exec_pc_we", pc_we, e_m.pc_we);
          check("exec_halted", halted, e_m.halted);
          check("exec_fault", fault, e_m.fault);
        end
      end
      if (pc_we) begin
        if (ret_q.size() == 0) bound_fail("retire_unexpected");
        else begin
          r_m = ret_q.pop_front();
          check("ret_pc_sel", pc_sel, r_m.pc_sel);
          check("ret_rf_we", rf_we, r_m.rf_we);
          check("ret_rd", rd, r_m.rd);
          check("ret_wb_sel", wb_sel, r_m.wb_sel);
          check("ret_cycle_cnt", cycle_cnt, r_m.cyc);
          check("ret_instret_cnt", instret_cnt, r_m.ret);
          check("ret_mem_cycles", mon_mem, r_m.mem_cyc);
          check("ret_store_cycles", mon_st, r_m.st_cyc);
        end
        mon_mem = 0; mon_st = 0;
      end
      exec_due = prev_ir;
      prev_ir  = ir_we;
    end
  end

  // Reference model at instruction granularity, applied during the FETCH cycle.
  task automatic issue(input logic [31:0] word, input logic bt, input int w, input bit expect_retire);
    logic [6:0]  opc;
    logic [2:0]  f3;
    bit          is_r, is_i, ld, st, br, jal, jalr, hlt, legal;
    exec_exp_t   e;
    ret_exp_t    r;
    int unsigned lat;
    opc  = word[6:0];
    f3   = word[14:12];
    is_r = (opc == 7'h33); is_i = (opc == 7'h13); ld   = (opc == 7'h03);
    st   = (opc == 7'h23); br   = (opc == 7'h63); jal  = (opc == 7'h6F);
    jalr = (opc == 7'h67); hlt  = (opc == 7'h00);
    legal = is_r | is_i | ld | st | br | jal | jalr;
    instr = word; branch_taken = bt; cur_w = w;
    e = '{default: '0};
    e.rs1 = word[19:15]; e.rs2 = word[24:20];
    e.halted = hlt; e.fault = !legal && !hlt;
    if (legal) begin
      e.op1    = !(br || jal);
      e.op2    = !is_r;
      e.subsra = is_r ? word[30] : ((is_i && f3 == 3'd5) ? word[30] : 1'b0);
      e.func3  = (is_r || is_i) ? f3 : 3'd0;
      e.br_op  = br ? f3 : 3'd0;
      e.pc_we  = br;
    end
    exec_q.push_back(e);
    if (legal && expect_retire) begin
      lat       = br ? 3 : ((ld || st) ? 5 + w : 4);
      r.pc_sel  = br ? bt : (jal || jalr);
      r.rf_we   = !(br || st) && (word[11:7] != 5'd0);
      r.rd      = word[11:7];
      r.wb_sel  = (br || ld) ? 2'b00 : ((jal || jalr) ? 2'b10 : 2'b01);
      r.cyc     = model_cycles + lat - 1;
      r.ret     = model_retired;
      r.mem_cyc = (ld || st) ? w + 1 : 0;
      r.st_cyc  = st ? w + 1 : 0;
      ret_q.push_back(r);
      model_cycles += lat;
      model_retired++;
    end
  endtask

  task automatic wait_fetch(output bit found);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ir_we) begin found = 1'b1; break; end
    end
    if (!found) bound_fail("wait_fetch");
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exec_q.size() == 0 && ret_q.size() == 0) begin done = 1'b1; break; end
    end
    if (!done) bound_fail("wait_drain");
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; run = 1'b0;
    exec_q.delete(); ret_q.delete();
    model_cycles = 0; model_retired = 0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic logic [31:0] rand_word();
    logic [6:0] opc;
    logic [31:0] word;
    case ($urandom_range(0, 6))
      0: opc = 7'h33; 1: opc = 7'h13; 2: opc = 7'h03; 3: opc = 7'h23;
      4: opc = 7'h63; 5: opc = 7'h6F; default: opc = 7'h67;
    endcase
    word = $urandom;
    word[6:0] = opc;
    return word;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_ir_we", ir_we, 0);     check("rst_pc_we", pc_we, 0);
    check("rst_mem_req", mem_req, 0); check("rst_halted", halted, 0);
    check("rst_fault", fault, 0);     check("rst_cycle_cnt", cycle_cnt, 0);
    check("rst_instret", instret_cnt, 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_no_fetch", ir_we, 0);
    check("idle_cycle_cnt", cycle_cnt, 0);

    // add x3,x1,x2 with run dropped mid-instruction
    run = 1'b1;
    wait_fetch(ok);
    issue(32'h002081B3, 1'b0, 0, 1'b1);
    @(negedge clk); run = 1'b0;
    wait_drain();
    seen = 0;
    repeat (5) begin @(negedge clk); if (ir_we) seen++; end
    check("add_then_idle", seen, 0);
    check("add_cycle_cnt", cycle_cnt, 4);
    check("add_instret", instret_cnt, 1);

    // beq taken / not taken, lw with 3 waits, then random stream
    run = 1'b1;
    for (int n = 0; n < 64; n++) begin
      wait_fetch(ok);
      case (n)
        0: issue(32'h00208063, 1'b1, 0, 1'b1);
        1: issue(32'h00208063, 1'b0, 0, 1'b1);
        2: issue(32'h0000A183, 1'b0, 3, 1'b1);
        default: issue(rand_word(), 1'($urandom_range(0, 1)), $urandom_range(0, 4), 1'b1);
      endcase
    end
    @(negedge clk); run = 1'b0;
    wait_drain();
    repeat (3) @(negedge clk);
    check("rand_cycle_cnt", cycle_cnt, model_cycles);
    check("rand_instret", instret_cnt, model_retired);

    // halt opcode
    do_reset(); run = 1'b1;
    wait_fetch(ok);
    issue(32'h00000000, 1'b0, 0, 1'b0);
    @(negedge clk); run = 1'b0;
    repeat (6) @(negedge clk);
    check("halt_halted", halted, 1);
    check("halt_cycle_frozen", cycle_cnt, 2);
    check("halt_instret", instret_cnt, 0);
    check("halt_no_fetch", ir_we, 0);

    // illegal opcode 0x7F
    do_reset(); run = 1'b1;
    wait_fetch(ok);
    issue(32'h0000007F, 1'b0, 0, 1'b0);
    @(negedge clk); run = 1'b0;
    repeat (6) @(negedge clk);
    check("illegal_fault", fault, 1);
    check("illegal_halted", halted, 0);
    check("illegal_cycle_cnt", cycle_cnt, 2);

    // sw with memory never ready
    do_reset(); run = 1'b1;
    wait_fetch(ok);
    issue(32'h0020A023, 1'b0, 100000, 1'b0);
    @(negedge clk); run = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (fault) begin ok = 1'b1; break; end
    end
    if (!ok) bound_fail("timeout_fault");
    @(negedge clk);
    check("timeout_mem_cycles", mon_mem, WAIT_LIMIT);
    check("timeout_store_cycles", mon_st, WAIT_LIMIT);
    check("timeout_mem_req_off", mem_req, 0);
    check("timeout_dm_we_off", dm_we, 0);
    check("timeout_cycle_cnt", cycle_cnt, 3 + WAIT_LIMIT);
    repeat (5) @(negedge clk);
    check("timeout_fault_sticky", fault, 1);

    // asynchronous reset in the middle of a load's MEM phase
    do_reset(); run = 1'b1;
    wait_fetch(ok);
    issue(32'h0000A183, 1'b0, 100000, 1'b0);
    @(negedge clk); run = 1'b0;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (mem_req) seen++;
      if (seen == 3) break;
    end
    check("midmem_reached", seen, 3);
    check("midmem_cycle_cnt", cycle_cnt, 5);
    reset = 1'b0;
    #1;
    check("async_mem_req", mem_req, 0);   check("async_dm_we", dm_we, 0);
    check("async_cycle_cnt", cycle_cnt, 0);
    check("async_instret", instret_cnt, 0);
    check("async_rd", rd, 0);             check("async_rs1", rs1, 0);
    check("async_alu_func3", alu_func3, 0);
    exec_q.delete(); ret_q.delete();
    @(negedge clk); reset = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_idle", ir_we, 0);
    check("post_reset_cycle_cnt", cycle_cnt, 0);

    check("scoreboard_exec_empty", exec_q.size(), 0);
    check("scoreboard_ret_empty", ret_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle sequencer for the RV32I datapath: PC, sum, instruction memory, register file, imm unit, operand muxes, ALU, Branch unit, data memory and write-back mux. It replaces the single edge-triggered decode with a registered Moore FSM. The FSM steps each instruction through FETCH/DECODE/EXEC/MEM/WB, handshakes with data memory, and detects halt and illegal opcodes. It also keeps cycle and retired-instruction counters.

## Interface
- `CNT_W`, 32: width of `cycle_cnt`/`instret_cnt`
- `WAIT_LIMIT`, 15: maximum MEM cycles without `mem_ready` before fault
- `clk` in 1: clock, rising edge
- `reset` in 1: asynchronous, active-low reset
- `run` in 1: enables instruction sequencing
- `instr` in 32: instruction register contents
- `branch_taken` in 1: `branch_next` from the Branch unit
- `mem_ready` in 1: data memory completion
- `ir_we` out 1: latch instruction register
- `pc_we` out 1: PC update
- `pc_sel` out 1: 0 = sum (PC+4), 1 = ALU result
- `rs1`, `rs2`, `rd` out 5 each: register addresses
- `rf_we` out 1: register file write
- `alu_func3` out 3; `alu_subsra` out 1: ALU operation
- `op1_sel` out 1: 0 = PC, 1 = rs1
- `op2_sel` out 1: 0 = rs2, 1 = imm
- `wb_sel` out 2: 00 = dm, 01 = ALU, 10 = PC+4
- `br_op` out 3: Branch unit function
- `mem_req` out 1; `dm_we` out 1: data memory request, store enable
- `halted` out 1; `fault` out 1: sticky status
- `cycle_cnt`, `instret_cnt` out `CNT_W` each: performance counters

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, FAULT.
- All outputs are registered. Enables are 1 only in the listed state; otherwise 0.
- **IDLE**: if `run`=1, go to FETCH.
- **FETCH**: `ir_we`=1, then DECODE.
- **DECODE**: register the fields from `instr`.
  - Opcode 0110011 (R), 0010011 (I-ALU), 0000011 (load), 0100011 (store), 1100011 (branch), 1101111 (JAL), 1100111 (JALR): go to EXEC.
  - Opcode 0000000: go to HALT.
  - Any other opcode: go to FAULT.
- **EXEC**:
  - Operand selects per opcode: `op1_sel`=0 for branch/JAL, 1 otherwise. `op2_sel`=0 only for R.
  - `alu_subsra`=`instr[30]` for R, and for I-ALU when func3=101; 0 otherwise.
  - `alu_func3`=func3 for R and I-ALU; 000 otherwise.
  - Branch: `br_op`=func3, `pc_we`=1, `pc_sel`=`branch_taken`, retire, next state FETCH.
  - Load/store: go to MEM. All other opcodes: go to WB.
- **MEM**:
  - `mem_req`=1; `dm_we`=1 for stores; `alu_func3`=func3 drives DMCtrl.
  - On `mem_ready`=1: go to WB.
  - If `mem_ready` stays 0 for `WAIT_LIMIT` consecutive MEM cycles: go to FAULT.
- **WB**:
  - `rf_we`=1 unless store or rd=0.
  - `wb_sel`: 00 for load, 10 for JAL/JALR, 01 otherwise.
  - `pc_we`=1; `pc_sel`=1 for JAL/JALR, 0 otherwise.
  - Retire, then FETCH if `run`=1, else IDLE.
- **Retire**: `instret_cnt` += 1 and wraps modulo 2^`CNT_W`.
- **Counters**: `cycle_cnt` += 1 in every state except IDLE, HALT and FAULT; wraps.
- **HALT**: `halted`=1, sticky until reset. **FAULT**: `fault`=1, sticky until reset.
- `run` deasserted mid-instruction: the instruction completes, then the FSM goes to IDLE.

## Timing
- Reset (`reset`=0) forces state IDLE and every output, counter and field register to 0 immediately, asynchronously.
- Reset in MEM: `mem_req`/`dm_we` drop without waiting for a clock.
- Latency (FETCH to retire):
  - branch: 3 cycles
  - R/I/JAL/JALR: 4 cycles
  - load/store: 5+w cycles, w = wait cycles
- Handshake: `mem_ready` is sampled only in MEM. Ready in the first MEM cycle gives zero-wait (MEM lasts 1 cycle). `mem_ready` outside MEM is ignored.
- The wait counter resets on entry to MEM. Fault occurs on the edge ending MEM cycle `WAIT_LIMIT` when `mem_ready` is still 0.
- `pc_we` and `rf_we` pulses last exactly 1 cycle per instruction.

## Structure
- Package `ctrl_pkg` holds:
  - state enum
  - opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_HALT)
  - `wb_sel` encodings (WB_DM, WB_ALU, WB_PC4)
  - `op1_sel`/`op2_sel` encodings
- Sub-module `instr_decoder`: combinational mapping from opcode to instruction class and mux selects. `multicycle_ctrl` holds the FSM, wait counter and performance counters.

## Test plan
- add x3,x1,x2 (0x002081B3), `run`=1 → states FETCH/DECODE/EXEC/WB; `rf_we` pulses in cycle 4 with rd=3, `wb_sel`=01; `instret_cnt`=1, `cycle_cnt`=4.
- lw, `mem_ready` held 0 for 3 MEM cycles then 1 → `mem_req` high 4 cycles; WB with `wb_sel`=00; retire on cycle 8.
- sw with `mem_ready` never asserted, `WAIT_LIMIT`=15 → `fault`=1 after 15 MEM cycles, `dm_we`=0 thereafter; stays faulted until reset.
- beq, `branch_taken`=1 → `pc_sel`=1, `pc_we`=1 in cycle 3, next state FETCH; `branch_taken`=0 → `pc_sel`=0.
- instr=0x00000000 → `halted`=1 after DECODE, counters frozen; opcode 0x7F → `fault`=1.
- `reset` asserted mid-MEM → `mem_req`=0 immediately; all outputs and counters 0; FSM in IDLE.
